// File: rtl/instr_dispatch_if.sv
// Handshake and memory bus between the instruction sequencer (master) and
// the instruction memory, DDR loader and execution units (slave).
interface instr_dispatch_if #(
  parameter int INSTR_W = 64,
  parameter int ADDR_W  = 10,
  parameter int N_UNITS = 4,
  parameter int CNT_W   = 32
);
  logic               acc_enable;
  logic               i_mem_empty;
  logic [ADDR_W-1:0]  i_mem_addr;
  logic               i_mem_rd_en;
  logic [INSTR_W-1:0] i_mem_din;
  logic               fetch_req;
  logic               fetch_done;
  logic [INSTR_W-1:0] instr_out;
  logic [N_UNITS-1:0] unit_valid;
  logic [N_UNITS-1:0] unit_ready;
  logic [N_UNITS-1:0] unit_done;
  logic               busy;
  logic               halted;
  logic               illegal;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  acc_enable, i_mem_empty, i_mem_din, fetch_done, unit_ready, unit_done,
    output i_mem_addr, i_mem_rd_en, fetch_req, instr_out, unit_valid,
           busy, halted, illegal, retired
  );

  modport slave (
    output acc_enable, i_mem_empty, i_mem_din, fetch_done, unit_ready, unit_done,
    input  i_mem_addr, i_mem_rd_en, fetch_req, instr_out, unit_valid,
           busy, halted, illegal, retired
  );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// Instruction sequencer: refills instruction memory from DDR, then fetches,
// decodes and dispatches each instruction to an execution unit until HALT.
module instr_dispatch_fsm #(
  parameter int INSTR_W = 64,
  parameter int ADDR_W  = 10,
  parameter int N_UNITS = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  instr_dispatch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_REFILL   = 3'd2,
    S_READ     = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DISPATCH = 3'd5,
    S_WAIT     = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] OP_UNITS = 4'(N_UNITS);

  function automatic logic [N_UNITS-1:0] unit_sel(input logic [3:0] op);
    if (op < OP_UNITS) begin
      unit_sel = N_UNITS'(1'b1) << op;
    end else begin
      unit_sel = {N_UNITS{1'b0}};
    end
  endfunction

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [CNT_W-1:0]   retired_r;
  logic               illegal_r;
  logic [INSTR_W-1:0] instr_r, instr_next_s;
  logic [N_UNITS-1:0] unit_valid_r, unit_valid_s;
  logic               fetch_req_r, fetch_req_s;
  logic               rd_en_r, rd_en_s;
  logic               busy_r, busy_s;
  logic               halted_r, halted_s;
  logic [3:0]         op_cur_s;
  logic [N_UNITS-1:0] sel_cur_s;
  logic               retire_s;
  logic               illegal_hit_s;

  assign op_cur_s  = instr_r[INSTR_W-1 -: 4];
  assign sel_cur_s = unit_sel(op_cur_s);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; retire is folded into the DISPATCH/WAIT exit
  always_comb begin
    state_s       = state_r;
    retire_s      = 1'b0;
    illegal_hit_s = 1'b0;
    case (state_r)
      S_IDLE:    if (bus.acc_enable) state_s = S_CHECK; else state_s = S_IDLE;
      S_CHECK:   if (bus.i_mem_empty) state_s = S_REFILL; else state_s = S_READ;
      S_REFILL:  if (bus.fetch_done) state_s = S_READ; else state_s = S_REFILL;
      S_READ:    state_s = S_CAPTURE;
      S_CAPTURE: state_s = S_DISPATCH;
      S_DISPATCH: begin
        if (op_cur_s < OP_UNITS) begin
          if (|(bus.unit_ready & sel_cur_s)) state_s = S_WAIT; else state_s = S_DISPATCH;
        end else if (op_cur_s == OP_HALT) begin
          state_s = S_HALT;
        end else begin
          retire_s = 1'b1;
          if (op_cur_s != OP_NOP) illegal_hit_s = 1'b1; else illegal_hit_s = 1'b0;
        end
      end
      S_WAIT:    if (|(bus.unit_done & sel_cur_s)) retire_s = 1'b1; else retire_s = 1'b0;
      S_HALT:    if (bus.acc_enable) state_s = S_HALT; else state_s = S_IDLE;
      default:   state_s = S_IDLE;
    endcase
    if (retire_s) begin
      state_s = bus.acc_enable ? S_CHECK : S_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    instr_next_s = (state_r == S_CAPTURE) ? bus.i_mem_din : instr_r;
    unit_valid_s = (state_s == S_DISPATCH) ? unit_sel(instr_next_s[INSTR_W-1 -: 4])
                                           : {N_UNITS{1'b0}};
    fetch_req_s  = (state_s == S_REFILL);
    rd_en_s      = (state_s == S_READ);
    busy_s       = (state_s != S_IDLE) && (state_s != S_HALT);
    halted_s     = (state_s == S_HALT);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_valid_r <= {N_UNITS{1'b0}};
      fetch_req_r  <= 1'b0;
      rd_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      unit_valid_r <= unit_valid_s;
      fetch_req_r  <= fetch_req_s;
      rd_en_r      <= rd_en_s;
      busy_r       <= busy_s;
      halted_r     <= halted_s;
    end
  end

  // Program counter, retire counter, sticky illegal flag and instruction latch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= {ADDR_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
      illegal_r <= 1'b0;
      instr_r   <= {INSTR_W{1'b0}};
    end else begin
      if (retire_s) begin
        pc_r      <= pc_r + ADDR_W'(1);
        retired_r <= retired_r + CNT_W'(1);
      end else if (state_r == S_HALT && !bus.acc_enable) begin
        pc_r <= {ADDR_W{1'b0}};
      end
      if (state_r == S_IDLE && bus.acc_enable) begin
        illegal_r <= 1'b0;
      end else if (illegal_hit_s) begin
        illegal_r <= 1'b1;
      end
      instr_r <= instr_next_s;
    end
  end

  assign bus.i_mem_addr  = pc_r;
  assign bus.i_mem_rd_en = rd_en_r;
  assign bus.fetch_req   = fetch_req_r;
  assign bus.instr_out   = instr_r;
  assign bus.unit_valid  = unit_valid_r;
  assign bus.busy        = busy_r;
  assign bus.halted      = halted_r;
  assign bus.illegal     = illegal_r;
  assign bus.retired     = retired_r;

endmodule
